// File: rtl/core_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------
// core_pkg : shared arbiter state/requester types and bus widths (rev 1.0)
// ------------------------------------------------------------------------
package core_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D  = 1'b1;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ------------------------------------------------------------------------
// mem_port_arbiter_if : IF/data request channels and memory port (rev 1.0)
// ------------------------------------------------------------------------
interface mem_port_arbiter_if
  import core_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic                  if_req_valid;
  logic                  if_req_ready;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_rsp_valid;
  logic [DATA_W-1:0]     if_rdata;

  logic                  d_req_valid;
  logic                  d_req_ready;
  logic                  d_we;
  logic [DATA_W/8-1:0]   d_be;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic                  d_rsp_valid;
  logic [DATA_W-1:0]     d_rdata;

  logic                  mem_en;
  logic                  mem_we;
  logic [DATA_W/8-1:0]   mem_be;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;

  // Requesters and the memory sit on the master side; the arbiter is the slave.
  modport master (
    output if_req_valid, if_addr,
    input  if_req_ready, if_rsp_valid, if_rdata,
    output d_req_valid, d_we, d_be, d_addr, d_wdata,
    input  d_req_ready, d_rsp_valid, d_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  if_req_valid, if_addr,
    output if_req_ready, if_rsp_valid, if_rdata,
    input  d_req_valid, d_we, d_be, d_addr, d_wdata,
    output d_req_ready, d_rsp_valid, d_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata
  );

endinterface
`default_nettype wire

// File: rtl/mem_lat_timer.sv
`default_nettype none
// ------------------------------------------------------------------------
// mem_lat_timer : loadable down-counter timing one memory access (rev 1.0)
// ------------------------------------------------------------------------
module mem_lat_timer #(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic done,
  output logic done_next
);

  localparam int CW = $clog2(LAT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (start) begin
      r_cnt <= CW'(LAT);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // done marks the last outstanding cycle; done_next predicts it one cycle early
  assign done      = (r_cnt == CW'(1));
  assign done_next = start ? (LAT == 1) : ({1'b0, r_cnt} == (CW + 1)'(2));

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------------
// mem_port_arbiter : IF/data arbiter for the unified memory port (rev 1.0)
// ------------------------------------------------------------------------
module mem_port_arbiter
  import core_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               test_enable,
  mem_port_arbiter_if.slave  bus,
  output logic [31:0]        if_wait_cnt,
  output logic [31:0]        d_wait_cnt
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  arb_state_t          r_state;
  logic                r_owner;
  logic                r_we;
  logic                r_if_rsp;
  logic                r_d_rsp;
  logic [SW-1:0]       r_starve;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_d_rdata;

  logic                w_done;
  logic                w_done_next;
  logic                w_free;
  logic                w_grant_d;
  logic                w_grant_if;
  logic                w_issue;
  logic                w_next_owner;
  logic [DATA_W-1:0]   w_rsp_rdata;

  mem_lat_timer #(
    .LAT (MEM_LAT)
  ) u_lat_timer (
    .clk       (clk),
    .rst       (rst),
    .start     (w_issue),
    .done      (w_done),
    .done_next (w_done_next)
  );

  // The port can be regranted in the cycle the outstanding response returns
  assign w_free       = (r_state == ARB_IDLE) || ((r_state == ARB_BUSY) && w_done);
  assign w_grant_d    = w_free && bus.d_req_valid &&
                        ((r_starve < SW'(STARVE_MAX)) || !bus.if_req_valid);
  assign w_grant_if   = w_free && !w_grant_d && bus.if_req_valid;
  assign w_issue      = w_grant_d || w_grant_if;
  assign w_next_owner = w_issue ? (w_grant_d ? REQ_D : REQ_IF) : r_owner;

  assign bus.d_req_ready  = w_grant_d;
  assign bus.if_req_ready = w_grant_if;

  always_comb begin
    bus.mem_en    = w_issue;
    bus.mem_we    = 1'b0;
    bus.mem_be    = '0;
    bus.mem_addr  = {ADDR_W{1'b0}};
    bus.mem_wdata = {DATA_W{1'b0}};
    if (w_grant_d) begin
      bus.mem_we    = bus.d_we;
      bus.mem_be    = bus.d_be;
      bus.mem_addr  = bus.d_addr;
      bus.mem_wdata = bus.d_wdata;
    end else if (w_grant_if) begin
      bus.mem_be    = '1;
      bus.mem_addr  = bus.if_addr;
    end
  end

  // Response data is forwarded straight from memory in the strobe cycle and
  // held in the per-requester register afterwards.
  assign w_rsp_rdata      = r_we ? {DATA_W{1'b0}} : bus.mem_rdata;
  assign bus.if_rsp_valid = r_if_rsp;
  assign bus.d_rsp_valid  = r_d_rsp;
  assign bus.if_rdata     = r_if_rsp ? bus.mem_rdata : r_if_rdata;
  assign bus.d_rdata      = r_d_rsp  ? w_rsp_rdata   : r_d_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ARB_IDLE;
      r_owner     <= REQ_IF;
      r_we        <= 1'b0;
      r_if_rsp    <= 1'b0;
      r_d_rsp     <= 1'b0;
      r_starve    <= '0;
      r_if_rdata  <= {DATA_W{1'b0}};
      r_d_rdata   <= {DATA_W{1'b0}};
      if_wait_cnt <= 32'd0;
      d_wait_cnt  <= 32'd0;
    end else begin
      if (w_issue) begin
        r_state <= ARB_BUSY;
        r_owner <= w_next_owner;
        r_we    <= w_grant_d && bus.d_we;
      end else if (w_done) begin
        r_state <= ARB_IDLE;
      end

      r_if_rsp <= w_done_next && (w_next_owner == REQ_IF);
      r_d_rsp  <= w_done_next && (w_next_owner == REQ_D);

      if (r_if_rsp) begin
        r_if_rdata <= bus.mem_rdata;
      end
      if (r_d_rsp) begin
        r_d_rdata <= w_rsp_rdata;
      end

      if (w_grant_if) begin
        r_starve <= '0;
      end else if (w_grant_d && bus.if_req_valid && (r_starve < SW'(STARVE_MAX))) begin
        r_starve <= r_starve + SW'(1);
      end

      if (test_enable) begin
        if (bus.if_req_valid && !w_grant_if) begin
          if_wait_cnt <= if_wait_cnt + 32'd1;
        end
        if (bus.d_req_valid && !w_grant_d) begin
          d_wait_cnt <= d_wait_cnt + 32'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_mem_port_arbiter : scoreboard bench for mem_port_arbiter (rev 1.0)
// ------------------------------------------------------------------------
module tb_mem_port_arbiter;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        test_enable = 1'b0;
  logic [31:0] if_wait2, d_wait2, if_wait1, d_wait1;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic        owner;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] rd_at[int];

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus2 ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) u_dut2 (
    .clk         (clk),
    .rst         (rst),
    .test_enable (test_enable),
    .bus         (bus2),
    .if_wait_cnt (if_wait2),
    .d_wait_cnt  (d_wait2)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
    .clk         (clk),
    .rst         (rst),
    .test_enable (test_enable),
    .bus         (bus1),
    .if_wait_cnt (if_wait1),
    .d_wait_cnt  (d_wait1)
  );

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEAD_BEEF : ((a ^ 32'h5A5A_0000) + 32'h1);
  endfunction

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_counter();
    forever begin
      @(posedge clk);
      cyc++;
    end
  endtask

  // Memory model for the MEM_LAT=2 instance: read data valid in cycle T+2
  task automatic mem_model();
    forever begin
      @(posedge clk);
      #1;
      if (rd_at.exists(cyc)) bus2.mem_rdata = rd_at[cyc];
      else                   bus2.mem_rdata = 32'hBAD0_BAD0;
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        sb.delete();
        rd_at.delete();
      end else begin
        if (bus2.if_rsp_valid || bus2.d_rsp_valid) begin
          if (sb.size() == 0) begin
            check("rsp_unexpected", 64'(1), 64'(0));
          end else begin
            e = sb.pop_front();
            check("rsp_owner", 64'(bus2.d_rsp_valid), 64'(e.owner));
            check("rsp_single", 64'(bus2.if_rsp_valid & bus2.d_rsp_valid), 64'(0));
            check("rsp_cycle", 64'(cyc), 64'(e.due));
            check("rsp_rdata", 64'(bus2.d_rsp_valid ? bus2.d_rdata : bus2.if_rdata), 64'(e.data));
          end
        end
        if (bus2.mem_en) begin
          e.owner = bus2.d_req_ready ? REQ_D : REQ_IF;
          e.data  = bus2.mem_we ? 32'h0 : mem_fn(bus2.mem_addr);
          e.due   = cyc + 2;
          sb.push_back(e);
          if (!bus2.mem_we) rd_at[cyc + 2] = mem_fn(bus2.mem_addr);
        end
      end
    end
  endtask

  task automatic wait_accept(input logic is_d, input string tag);
    logic got;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = is_d ? bus2.d_req_ready : bus2.if_req_ready;
    end
    check(tag, 64'(got), 64'(1));
  endtask

  initial begin
    logic [31:0] d_wait_before;
    logic [1:0]  grant;

    bus2.if_req_valid = 1'b0; bus2.if_addr = '0;
    bus2.d_req_valid = 1'b0; bus2.d_we = 1'b0; bus2.d_be = '0; bus2.d_addr = '0; bus2.d_wdata = '0;
    bus2.mem_rdata = '0;
    bus1.if_req_valid = 1'b0; bus1.if_addr = '0;
    bus1.d_req_valid = 1'b0; bus1.d_we = 1'b0; bus1.d_be = '0; bus1.d_addr = '0; bus1.d_wdata = '0;
    bus1.mem_rdata = '0;

    fork
      cyc_counter();
      mem_model();
      monitor();
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_if_rsp", 64'(bus2.if_rsp_valid), 64'(0));
    check("rst_d_rsp", 64'(bus2.d_rsp_valid), 64'(0));
    check("rst_if_rdata", 64'(bus2.if_rdata), 64'(0));
    check("rst_d_rdata", 64'(bus2.d_rdata), 64'(0));
    check("rst_mem_en", 64'(bus2.mem_en), 64'(0));
    check("rst_wait_cnt", 64'(if_wait2), 64'(0));
    tick();
    rst = 1'b1;
    test_enable = 1'b1;

    // Single IF read
    tick();
    bus2.if_req_valid = 1'b1; bus2.if_addr = 32'h100;
    @(negedge clk);
    check("t1_if_ready", 64'(bus2.if_req_ready), 64'(1));
    check("t1_mem_en", 64'(bus2.mem_en), 64'(1));
    check("t1_mem_addr", 64'(bus2.mem_addr), 64'(32'h100));
    check("t1_mem_be", 64'(bus2.mem_be), 64'(4'hF));
    check("t1_mem_we", 64'(bus2.mem_we), 64'(0));
    tick();
    bus2.if_req_valid = 1'b0; bus2.if_addr = '0;
    @(negedge clk);
    check("t1_mem_en_t1", 64'(bus2.mem_en), 64'(0));
    check("t1_mem_addr_idle", 64'(bus2.mem_addr), 64'(0));
    check("t1_mem_be_idle", 64'(bus2.mem_be), 64'(0));
    check("t1_no_rsp_t1", 64'(bus2.if_rsp_valid), 64'(0));
    @(negedge clk);
    check("t1_rsp_t2", 64'(bus2.if_rsp_valid), 64'(1));
    check("t1_rdata_t2", 64'(bus2.if_rdata), 64'(32'hDEAD_BEEF));
    @(negedge clk);
    check("t1_rsp_t3", 64'(bus2.if_rsp_valid), 64'(0));
    check("t1_rdata_hold", 64'(bus2.if_rdata), 64'(32'hDEAD_BEEF));

    // Data write
    tick();
    bus2.d_req_valid = 1'b1; bus2.d_we = 1'b1; bus2.d_be = 4'hF;
    bus2.d_addr = 32'h2000; bus2.d_wdata = 32'h1234_5678;
    @(negedge clk);
    check("t2_d_ready", 64'(bus2.d_req_ready), 64'(1));
    check("t2_mem_we", 64'(bus2.mem_we), 64'(1));
    check("t2_mem_be", 64'(bus2.mem_be), 64'(4'hF));
    check("t2_mem_addr", 64'(bus2.mem_addr), 64'(32'h2000));
    check("t2_mem_wdata", 64'(bus2.mem_wdata), 64'(32'h1234_5678));
    tick();
    bus2.d_req_valid = 1'b0; bus2.d_we = 1'b0; bus2.d_wdata = '0;
    @(negedge clk);
    @(negedge clk);
    check("t2_d_rsp", 64'(bus2.d_rsp_valid), 64'(1));
    check("t2_d_rdata", 64'(bus2.d_rdata), 64'(0));
    check("t2_no_if_rsp", 64'(bus2.if_rsp_valid), 64'(0));

    // Back-to-back: data read accepted in the IF response cycle
    tick();
    d_wait_before = d_wait2;
    bus2.if_req_valid = 1'b1; bus2.if_addr = 32'h300;
    @(negedge clk);
    check("b2b_issue_t0", 64'(bus2.mem_en), 64'(1));
    tick();
    bus2.if_req_valid = 1'b0;
    bus2.d_req_valid = 1'b1; bus2.d_we = 1'b0; bus2.d_addr = 32'h400;
    @(negedge clk);
    check("b2b_rdy_t1", 64'(bus2.d_req_ready), 64'(0));
    check("b2b_if_rdy_t1", 64'(bus2.if_req_ready), 64'(0));
    @(negedge clk);
    check("b2b_rdy_t2", 64'(bus2.d_req_ready), 64'(1));
    check("b2b_if_rsp_t2", 64'(bus2.if_rsp_valid), 64'(1));
    check("b2b_issue_t2", 64'(bus2.mem_en), 64'(1));
    tick();
    bus2.d_addr = 32'h500;
    @(negedge clk);
    check("b2b_rdy_t3", 64'(bus2.d_req_ready), 64'(0));
    @(negedge clk);
    check("b2b_rdy_t4", 64'(bus2.d_req_ready), 64'(1));
    check("b2b_d_rsp_t4", 64'(bus2.d_rsp_valid), 64'(1));
    check("b2b_issue_t4", 64'(bus2.mem_en), 64'(1));
    tick();
    bus2.d_req_valid = 1'b0;
    check("b2b_d_wait", 64'(d_wait2 - d_wait_before), 64'(2));
    repeat (3) @(negedge clk);

    // Reset during an outstanding read
    tick();
    bus2.if_req_valid = 1'b1; bus2.if_addr = 32'h900;
    @(negedge clk);
    check("rstx_issue", 64'(bus2.mem_en), 64'(1));
    tick();
    bus2.if_req_valid = 1'b0;
    #2 rst = 1'b0;
    @(negedge clk);
    check("rstx_no_rsp_t1", 64'(bus2.if_rsp_valid), 64'(0));
    @(negedge clk);
    check("rstx_no_rsp_t2", 64'(bus2.if_rsp_valid), 64'(0));
    check("rstx_if_rdata", 64'(bus2.if_rdata), 64'(0));
    tick();
    #1 rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rstx_no_rsp_after", 64'(bus2.if_rsp_valid | bus2.d_rsp_valid), 64'(0));
    end
    check("rstx_if_wait", 64'(if_wait2), 64'(0));
    check("rstx_d_wait", 64'(d_wait2), 64'(0));

    // Wait counters gated by test_enable, IF starved behind data
    for (int k = 0; k <= 10; k++) begin
      tick();
      if (k == 0) begin
        bus2.d_req_valid = 1'b1; bus2.d_we = 1'b0; bus2.d_addr = 32'h600;
      end
      if (k == 1) begin
        bus2.if_req_valid = 1'b1; bus2.if_addr = 32'h700;
      end
      test_enable = (k >= 6 && k <= 8);
      @(negedge clk);
      if (k == 0)  check("te_idle_ready", 64'(bus2.d_req_ready), 64'(1));
      if (k == 6)  check("te_off_cnt", 64'(if_wait2), 64'(0));
      if (k == 10) check("te_if_wins", 64'(bus2.if_req_ready), 64'(1));
    end
    tick();
    bus2.if_req_valid = 1'b0;
    check("te_on_cnt", 64'(if_wait2), 64'(3));
    wait_accept(1'b1, "te_d_accept");
    tick();
    bus2.d_req_valid = 1'b0;

    // Starvation ordering on the MEM_LAT=1 instance
    test_enable = 1'b1;
    bus1.if_req_valid = 1'b1; bus1.if_addr = 32'h40;
    bus1.d_req_valid = 1'b1; bus1.d_addr = 32'h80; bus1.d_be = 4'hF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      grant = bus1.d_req_ready ? 2'd1 : (bus1.if_req_ready ? 2'd2 : 2'd0);
      check($sformatf("grant_%0d", i), 64'(grant), 64'((i % 5 == 4) ? 2 : 1));
      tick();
    end
    bus1.if_req_valid = 1'b0;
    bus1.d_req_valid = 1'b0;
    check("starve_if_wait", 64'(if_wait1), 64'(8));
    check("starve_d_wait", 64'(d_wait1), 64'(2));

    repeat (5) @(negedge clk);
    check("sb_drain", 64'(sb.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single unified memory port between instruction fetch (IF) and the data/MEM stage.
- Uses a valid/ready request handshake and a fixed-latency response.
- Data requests win by default; a starvation counter guarantees IF progress.
- Exports per-requester wait-cycle counters to the performance monitor, gated by test_enable.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, cycles from memory issue to mem_rdata valid; legal range >= 1
- STARVE_MAX, 4, consecutive data grants with IF waiting before IF is forced

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- test_enable  in  1  enables wait counters
- if_req_valid  in  1  IF request
- if_req_ready  out  1  IF accept
- if_addr  in  ADDR_W  IF address
- if_rsp_valid  out  1  IF response strobe
- if_rdata  out  DATA_W  IF read data
- d_req_valid  in  1  data request
- d_req_ready  out  1  data accept
- d_we  in  1  1 = write
- d_be  in  DATA_W/8  byte enables
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_rsp_valid  out  1  data response strobe (reads and writes)
- d_rdata  out  DATA_W  data read data
- mem_en  out  1  memory issue strobe
- mem_we  out  1  memory write
- mem_be  out  DATA_W/8  memory byte enables
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after issue
- if_wait_cnt  out  32  cycles IF was valid but not accepted
- d_wait_cnt  out  32  cycles data was valid but not accepted

Behaviour:
- Reset (rst=0, async):
  - FSM to IDLE; lat_cnt, starve_cnt and both wait counters to 0.
  - All rsp_valid and rdata outputs to 0.
  - An outstanding access is dropped; no response is produced after reset releases.
- FSM states:
  - IDLE: port free.
  - BUSY: access outstanding, owner and we latched.
- Grant in IDLE, or in the final BUSY cycle:
  - if d_req_valid and (starve_cnt < STARVE_MAX or !if_req_valid), grant data;
  - else if if_req_valid, grant IF.
- Ready rules:
  - Ready is combinational and high only for the granted requester.
  - Ready never depends on its own valid beyond the grant rule.
  - Accept = valid & ready.
- Issue cycle T (accept):
  - mem_en=1 combinationally, with mem_* driven from the granted requester (IF: we=0, be=all ones, wdata=0).
  - When mem_en=0: mem_we, mem_be, mem_addr, mem_wdata are 0.
- Sequencing after issue at T:
  - FSM enters BUSY, lat_cnt counts 1..MEM_LAT.
  - At T+MEM_LAT the owner's rsp_valid=1 for exactly one cycle.
  - rdata is registered from mem_rdata (reads) or 0 (writes), and holds until the next response to that requester.
- Throughput:
  - A new request may be accepted in the response cycle (T+MEM_LAT), giving one access per MEM_LAT cycles.
  - If MEM_LAT=1, an access can be issued every cycle.
  - Ready is low for both requesters in T+1..T+MEM_LAT-1.
- starve_cnt:
  - +1 (saturating at STARVE_MAX) on each data accept while if_req_valid=1.
  - Cleared on IF accept.
  - Unchanged otherwise.
- Wait counters:
  - When test_enable=1, each counter increments on cycles where its valid=1 and ready=0.
  - 32-bit, wraps at 2^32-1 to 0.
  - Frozen when test_enable=0.
- Requests must hold valid and payload stable until accepted. The arbiter does not check this.
- Simultaneous valid with starve_cnt==STARVE_MAX: IF wins, starve_cnt becomes 0, d_wait_cnt increments.

Decomposition:
- Shared package (core_pkg, alongside existing core definitions):
  - arb_state_t enum {ARB_IDLE, ARB_BUSY};
  - requester id constants REQ_IF=0, REQ_D=1;
  - default ADDR_W/DATA_W.
- One sub-module: mem_lat_timer.
  - Loadable down-counter of width $clog2(MEM_LAT+1), with start/done.
  - Instantiated once to time the outstanding access.
- Arbitration and response muxing stay in the top module.

Test Plan:
- Reset release, then a single IF read of 0x100 with MEM_LAT=2, mem_rdata=0xDEADBEEF at T+2 -> mem_en only at T; if_rsp_valid one cycle at T+2; if_rdata=0xDEADBEEF.
- Data write (addr 0x2000, wdata 0x12345678, be 0xF) -> mem_we=1, mem_be=0xF at T; d_rsp_valid at T+2; d_rdata=0; no IF response.
- Both valid continuously, STARVE_MAX=4, MEM_LAT=1 -> grant order D,D,D,D,IF,D,D,D,D,IF; if_wait_cnt=8 after 10 accepts with test_enable=1.
- Back-to-back: data read accepted in the same cycle as the previous IF response (MEM_LAT=2) -> issues at T, T+2, T+4; ready low at T+1, T+3.
- Assert rst=0 at T+1 of an outstanding read, release at T+3 -> no rsp_valid ever for that access; FSM in IDLE; all counters 0.
- test_enable=0 with IF blocked for 5 cycles -> if_wait_cnt stays 0; set test_enable=1 for 3 blocked cycles -> if_wait_cnt=3.
